// File: rtl/fir_input_sequencer.sv
// Front end for the FIR filter input port: gathers coefficient sets and replays them
// as one CONFIG burst, and buffers samples in a FIFO that it issues as gap-free runs.
module fir_input_sequencer #(
    parameter int unsigned TAP_SIZE     = 3,
    parameter int unsigned NBR_OF_TAPS  = 3,
    parameter int unsigned X_N_SIZE     = 8,
    parameter int unsigned FIFO_DEPTH   = 4,
    parameter int unsigned START_THRESH = 2,
    parameter int unsigned INIT_CYCLES  = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [X_N_SIZE-1:0] in_data,
    input  logic                in_is_coeff,
    input  logic                in_valid,
    output logic                in_ready,
    output logic [X_N_SIZE-1:0] x_n,
    output logic                s_set_coeffs,
    output logic                s_axis_fir_tvalid,
    output logic                busy,
    output logic [7:0]          underrun_cnt
);

    localparam int unsigned PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W  = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned IDX_W  = (NBR_OF_TAPS > 1) ? $clog2(NBR_OF_TAPS) : 1;
    localparam int unsigned INIT_W = (INIT_CYCLES > 1) ? $clog2(INIT_CYCLES) : 1;

    typedef enum logic [2:0] {
        WAIT_INIT,
        IDLE,
        LOAD,
        GAP,
        STREAM
    } state_t;

    state_t              state_q, state_d;
    logic [INIT_W-1:0]   init_cnt_q, init_cnt_d;
    logic [IDX_W-1:0]    load_idx_q, load_idx_d;

    logic [TAP_SIZE-1:0] coeff_mem [NBR_OF_TAPS];
    logic [IDX_W-1:0]    coeff_idx_q;
    logic                pending_q;

    logic [X_N_SIZE-1:0] fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]    count_q;

    logic                fifo_empty, fifo_full;
    logic                push, pop, coeff_acc;
    logic                clear_pending, underrun_inc;
    logic [X_N_SIZE-1:0] x_n_d;
    logic                set_d, tvalid_d;

    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == CNT_W'(FIFO_DEPTH));

    // Next state and next registered outputs; outputs lag the state decision by one edge
    always_comb begin
        state_d       = state_q;
        init_cnt_d    = init_cnt_q;
        load_idx_d    = load_idx_q;
        x_n_d         = '0;
        set_d         = 1'b0;
        tvalid_d      = 1'b0;
        pop           = 1'b0;
        clear_pending = 1'b0;
        underrun_inc  = 1'b0;
        case (state_q)
            WAIT_INIT: begin
                if (init_cnt_q == INIT_W'(INIT_CYCLES - 1)) begin
                    state_d = IDLE;
                end else begin
                    init_cnt_d = init_cnt_q + 1'b1;
                end
            end
            IDLE: begin
                if (pending_q) begin
                    state_d    = LOAD;
                    load_idx_d = '0;
                end else if (count_q >= CNT_W'(START_THRESH)) begin
                    state_d = STREAM;
                end
            end
            LOAD: begin
                set_d = 1'b1;
                x_n_d = X_N_SIZE'($signed(coeff_mem[load_idx_q]));
                if (load_idx_q == IDX_W'(NBR_OF_TAPS - 1)) begin
                    state_d = GAP;
                end else begin
                    load_idx_d = load_idx_q + 1'b1;
                end
            end
            GAP: begin
                clear_pending = 1'b1;
                state_d       = IDLE;
            end
            STREAM: begin
                if (!fifo_empty) begin
                    pop      = 1'b1;
                    x_n_d    = fifo_mem[rd_ptr_q];
                    tvalid_d = 1'b1;
                end else begin
                    underrun_inc = 1'b1;
                    state_d      = IDLE;
                end
            end
            default: state_d = WAIT_INIT;
        endcase
    end

    // A pending set blocks every word so later samples see the new coefficients
    always_comb begin
        in_ready = 1'b0;
        if (!reset && state_q != WAIT_INIT && !pending_q) begin
            in_ready = in_is_coeff ? 1'b1 : (!fifo_full || pop);
        end
    end

    assign push      = in_valid && in_ready && !in_is_coeff;
    assign coeff_acc = in_valid && in_ready && in_is_coeff;
    assign busy      = (state_q != IDLE) || !fifo_empty || pending_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q           <= WAIT_INIT;
            init_cnt_q        <= '0;
            load_idx_q        <= '0;
            x_n               <= '0;
            s_set_coeffs      <= 1'b0;
            s_axis_fir_tvalid <= 1'b0;
            underrun_cnt      <= '0;
        end else begin
            state_q           <= state_d;
            init_cnt_q        <= init_cnt_d;
            load_idx_q        <= load_idx_d;
            x_n               <= x_n_d;
            s_set_coeffs      <= set_d;
            s_axis_fir_tvalid <= tvalid_d;
            if (underrun_inc && underrun_cnt != 8'hFF) begin
                underrun_cnt <= underrun_cnt + 8'd1;
            end
        end
    end

    // Coefficient collection
    always_ff @(posedge clk) begin
        if (reset) begin
            coeff_idx_q <= '0;
            pending_q   <= 1'b0;
        end else begin
            if (clear_pending) begin
                pending_q <= 1'b0;
            end
            if (coeff_acc) begin
                coeff_mem[coeff_idx_q] <= in_data[TAP_SIZE-1:0];
                if (coeff_idx_q == IDX_W'(NBR_OF_TAPS - 1)) begin
                    coeff_idx_q <= '0;
                    pending_q   <= 1'b1;
                end else begin
                    coeff_idx_q <= coeff_idx_q + 1'b1;
                end
            end
        end
    end

    // Sample FIFO
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                fifo_mem[wr_ptr_q] <= in_data;
                wr_ptr_q           <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: doc/fir_input_sequencer.md
Name: fir_input_sequencer

Overview:
Front end that drives the FIR filter's input interface (x_n, s_set_coeffs, s_axis_fir_tvalid) from a single upstream valid/ready word stream. It collects coefficient words into a complete set and replays them as one contiguous CONFIG burst. It buffers samples in a small FIFO and issues them as gap-free ACTIVE runs. It also honours the filter's post-reset setup window and its mode-change rules.

Parameters:
TAP_SIZE, 3, coefficient width
NBR_OF_TAPS, 3, coefficients per set / length of the load burst
X_N_SIZE, 8, sample width
FIFO_DEPTH, 4, sample FIFO entries (power of 2)
START_THRESH, 2, FIFO occupancy required to begin a stream run (1..FIFO_DEPTH)
INIT_CYCLES, 4, post-reset hold-off covering the filter setup phase

Ports:
clk  in  1  clock; all state updates on posedge
reset  in  1  synchronous, active-high
in_data  in  X_N_SIZE  upstream word
in_is_coeff  in  1  1 = coefficient word (uses in_data[TAP_SIZE-1:0]), 0 = sample
in_valid  in  1  upstream word valid
in_ready  out  1  word accepted on posedge when in_valid & in_ready
x_n  out  X_N_SIZE  to filter x_n, registered
s_set_coeffs  out  1  to filter, registered
s_axis_fir_tvalid  out  1  to filter, registered
busy  out  1  state != IDLE, or the FIFO is non-empty, or a full coefficient set is pending
underrun_cnt  out  8  stream runs that ended by FIFO empty; saturates at 255

Behaviour:
- Reset: reset, synchronous, active-high; clock clk.
  - Reset values: x_n=0, s_set_coeffs=0, s_axis_fir_tvalid=0, underrun_cnt=0, in_ready=0.
  - Reset empties the FIFO, discards any partial or pending coefficient set, and enters WAIT_INIT.
  - Reset mid-burst or mid-stream aborts immediately, with no trailing valid cycle.
- FSM states: WAIT_INIT, IDLE, LOAD, GAP, STREAM.
  - WAIT_INIT: all outputs 0, in_ready=0. Counts INIT_CYCLES cycles, then moves to IDLE.
  - IDLE: if a coefficient set is pending, go to LOAD. Else if FIFO count >= START_THRESH, go to STREAM. Pending coefficients take priority.
  - LOAD: exactly NBR_OF_TAPS consecutive cycles with s_set_coeffs=1, tvalid=0. x_n = coeff[i] sign-extended to X_N_SIZE, i = 0..NBR_OF_TAPS-1 in arrival order. The first-received coefficient therefore lands in the deepest filter tap. The last cycle goes to GAP.
  - GAP: one cycle with s_set_coeffs=0, tvalid=0, x_n=0, so the filter returns to IDLE. Clears the pending set, then goes to IDLE.
  - STREAM: each cycle, if the FIFO is non-empty, pop it: x_n = head, tvalid=1. If the FIFO is empty, drive tvalid=0, x_n=0, increment underrun_cnt (saturating) and go to IDLE.
  - A coefficient set completing during STREAM does not interrupt the run. It is loaded after the run ends.
- Coefficient collection:
  - Index register 0..NBR_OF_TAPS-1. The set becomes pending when the last word is accepted.
  - While a set is pending or LOAD is in progress, coefficient words are refused (in_ready=0 when in_is_coeff=1).
  - Sample words are also refused while a set is pending, so samples arriving after a new set use the new coefficients.
  - A partial set never blocks samples.
- Sample FIFO:
  - Accept when not full and not blocked. Full means in_ready=0 for sample words.
  - Simultaneous push and pop in STREAM is allowed when full, because the pop frees the slot in the same cycle. Count is unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
- in_ready: combinational from state, FIFO count, pending flag and in_is_coeff. It never depends on in_valid. It is 0 in WAIT_INIT.
- Latency: a sample accepted at edge t, into an empty FIFO with START_THRESH=1 in IDLE, appears on x_n with tvalid=1 after edge t+2.
- All outputs are registered on posedge. The filter samples on negedge, which gives a half-cycle margin.

Test Plan:
- Reset, then hold in_valid=1 sample 0x05 -> in_ready=0 for cycles 1-4. First acceptance at cycle 5; no filter output activity before that.
- Coefficient words 0x01, 0x07, 0x02 back-to-back -> s_set_coeffs=1 for exactly 3 cycles, x_n=0x01, 0xFF, 0x02. Then one GAP cycle with all outputs 0.
- Samples 0x10, 0x20, 0x30, 0x40 with START_THRESH=2 -> tvalid=1 for 4 consecutive cycles, x_n=0x10, 0x20, 0x30, 0x40. Then underrun_cnt=1.
- Fill FIFO with 4 samples while blocked, keep pushing during STREAM -> no in_ready=0 cycle while popping, no sample lost or duplicated, order preserved.
- Full coefficient set arrives mid-stream, then sample 0x55 -> stream run completes. 0x55 is stalled until GAP ends, then streamed after the LOAD burst.
- Assert reset during the second LOAD cycle -> next cycle all outputs 0. After WAIT_INIT no LOAD occurs without 3 new coefficient words.
